ws2812: RTL and testbench
=========================

WS2812 -- requirements
Module: ws2812

Interface
REQ-001 Parameter NUM_LEDS, default 4: number of LEDs in the chain, range 1..256.
REQ-002 Parameter T_BIT, default 15: bit period in clk cycles (1.25 us at 12 MHz).
REQ-003 Parameter T1H, default 9: high time in cycles for a '1' bit.
REQ-004 Parameter T0H, default 4: high time in cycles for a '0' bit.
REQ-005 Parameter T_RESET, default 600: latch low time in cycles (50 us at 12 MHz).
REQ-006 clk  input  1: sole clock, rising edge.
REQ-007 reset  input  1: one clock; reset is asynchronous and active-low (reset low = in reset).
REQ-008 rgb_data  input  24: colour word {R[23:16], G[15:8], B[7:0]}.
REQ-009 led_num  input  8: target LED index for a write.
REQ-010 write  input  1: one-cycle write strobe.
REQ-011 data  output  1: serial line to the first LED's DIN.

Function
REQ-012 Storage: led_reg[0..NUM_LEDS-1], 24 bits each.
REQ-013 Write: write=1 on an edge with led_num<NUM_LEDS stores rgb_data into led_reg[led_num]; led_num>=NUM_LEDS is ignored; writes accepted in any state.
REQ-014 State machine: state register, DATA=0, LATCH=1; leaves reset in LATCH.
REQ-015 LATCH: data=0 for T_RESET cycles, then go to DATA with led_counter=0 and bit index 0.
REQ-016 DATA: LEDs sent in order led_counter=0..NUM_LEDS-1, 24 bits each, MSB first, wire order G,R,B: {rgb[15:8], rgb[23:16], rgb[7:0]}.
REQ-017 The 24-bit word of LED k is snapshotted from led_reg[k] on the first cycle of its first bit; later writes take effect at the next snapshot of that LED.
REQ-018 Each bit lasts exactly T_BIT cycles: data=1 for T1H ('1') or T0H ('0') cycles, then 0 for the remainder.
REQ-019 After bit 23 of LED NUM_LEDS-1: led_counter wraps to 0 and the next state is LATCH; frames repeat continuously.
REQ-020 Bits are contiguous: no idle cycles between bits or between LEDs.
REQ-021 led_counter is $clog2(NUM_LEDS) bits wide (min 1) and always <= NUM_LEDS-1.
REQ-022 A write on the same edge as a snapshot of the same LED: the snapshot takes the old value.

Reset
REQ-023 While reset=0: data=0, every led_reg=0, state=LATCH, led_counter=0, bit and timing counters=0.
REQ-024 Reset asserted mid-frame aborts immediately (asynchronously); after release a full T_RESET latch precedes the next frame.

Configuration
REQ-025 With macro WS2812_BUSY_EN defined, output busy (1 bit) exists: 1 while state=DATA, 0 in LATCH and in reset.
REQ-026 Without WS2812_BUSY_EN, there is no busy port and behaviour is otherwise identical.

Structure
REQ-027 Package ws2812_pkg holds the state enum (DATA, LATCH) and the default timing constants.
REQ-028 Sub-module ws2812_bit_tx generates one T_BIT waveform from a bit value and start strobe, returning done; ws2812 holds storage, FSM and counters.

Verification
REQ-029 Reset released, no writes: data stays 0 for 600 cycles, then 4x24 '0' bits, each 4 high / 11 low cycles.
REQ-030 Write led_num=0, rgb_data=24'h000010: in frame 2, LED0 bit 19 (B bit 4) is 9 high / 6 low; all other bits are '0'.
REQ-031 Write led_num=3, rgb_data=24'hFF0000: LED3 bits 8..15 on the wire are '1' (R after G); all other bits '0'.
REQ-032 Write led_num=7 (NUM_LEDS=4): all led_reg unchanged; waveform identical to REQ-029.
REQ-033 Run 6 frames: each frame ends with led_counter=0 entering LATCH; frame length = 600+96*15 cycles.
REQ-034 Assert reset mid-bit in LED2: data goes 0 at once; after release 600 low cycles precede LED0 bit 0.

Source files
------------

// File: rtl/ws2812_pkg.sv
// WS2812 shared definitions: FSM state encoding, default timing, wire ordering.
package ws2812_pkg;

    typedef enum logic {
        DATA  = 1'b0,
        LATCH = 1'b1
    } state_t;

    // Default timing at 12 MHz
    localparam int DEF_NUM_LEDS = 4;
    localparam int DEF_T_BIT    = 15;
    localparam int DEF_T1H      = 9;
    localparam int DEF_T0H      = 4;
    localparam int DEF_T_RESET  = 600;

    // The LED expects green first, then red, then blue
    function automatic logic [23:0] wire_order(input logic [23:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// WS2812 single-bit waveform generator: one T_BIT period per start strobe.
// A start on the same edge as done begins the next bit with no idle cycle.
module ws2812_bit_tx
    import ws2812_pkg::*;
#(
    parameter int T_BIT = DEF_T_BIT,
    parameter int T1H   = DEF_T1H,
    parameter int T0H   = DEF_T0H
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic bit_val,
    output logic data,
    output logic done
);

    localparam int TW = clog2_min1(T_BIT);

    logic          active;
    logic [TW-1:0] cnt;
    logic          bit_r;

    // Bit period counter; a fresh start reloads it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active <= 1'b0;
            cnt    <= '0;
            bit_r  <= 1'b0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            bit_r  <= bit_val;
        end else if (active) begin
            if (cnt == TW'(T_BIT - 1)) begin
                active <= 1'b0;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign done = active && (cnt == TW'(T_BIT - 1));
    assign data = active && (32'(cnt) < (bit_r ? 32'(T1H) : 32'(T0H)));

endmodule

// File: rtl/ws2812.sv
// WS2812 LED chain driver: per-LED colour storage, frame FSM, serial output.
// Optional busy output enabled by defining WS2812_BUSY_EN.
module ws2812
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int T_BIT    = DEF_T_BIT,
    parameter int T1H      = DEF_T1H,
    parameter int T0H      = DEF_T0H,
    parameter int T_RESET  = DEF_T_RESET
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] rgb_data,
    input  logic [7:0]  led_num,
    input  logic        write,
    output logic        data
`ifdef WS2812_BUSY_EN
    ,
    output logic        busy
`endif
);

    localparam int CW = clog2_min1(NUM_LEDS);
    localparam int LW = clog2_min1(T_RESET);

    state_t         state, state_nx;
    logic [23:0]    led_reg [NUM_LEDS];
    logic [CW-1:0]  led_counter, led_counter_nx;
    logic [CW-1:0]  snap_idx;
    logic [23:0]    snap_word;
    logic [23:0]    shift_reg;
    logic [4:0]     bit_idx;
    logic [LW-1:0]  latch_cnt;
    logic           tx_start, tx_bit, tx_done, load_led;
    logic           latch_done, last_bit, last_led;

    assign latch_done = (state == LATCH) && (latch_cnt == LW'(T_RESET - 1));
    assign last_bit   = (bit_idx == 5'd23);
    assign last_led   = (led_counter == CW'(NUM_LEDS - 1));

    // Colour storage; out-of-range indices are dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_LEDS; i++) led_reg[i] <= '0;
        end else if (write && (32'(led_num) < NUM_LEDS)) begin
            led_reg[led_num[CW-1:0]] <= rgb_data;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= LATCH;
        else        state <= state_nx;
    end

    // Next state, bit launch and LED snapshot selection
    always_comb begin
        state_nx       = state;
        led_counter_nx = led_counter;
        tx_start       = 1'b0;
        load_led       = 1'b0;
        snap_idx       = '0;
        case (state)
            LATCH: begin
                if (latch_done) begin
                    state_nx       = DATA;
                    tx_start       = 1'b1;
                    load_led       = 1'b1;
                    led_counter_nx = '0;
                end
            end
            DATA: begin
                if (tx_done) begin
                    if (!last_bit) begin
                        tx_start = 1'b1;
                    end else if (!last_led) begin
                        tx_start       = 1'b1;
                        load_led       = 1'b1;
                        snap_idx       = led_counter + 1'b1;
                        led_counter_nx = snap_idx;
                    end else begin
                        state_nx       = LATCH;
                        led_counter_nx = '0;
                    end
                end
            end
            default: state_nx = LATCH;
        endcase
        // Snapshot reads led_reg before any same-edge write lands
        snap_word = wire_order(led_reg[snap_idx]);
        tx_bit    = load_led ? snap_word[23] : shift_reg[23];
    end

    // Frame counters and MSB-first shift register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_counter <= '0;
            latch_cnt   <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
        end else begin
            led_counter <= led_counter_nx;
            if ((state == LATCH) && !latch_done) latch_cnt <= latch_cnt + 1'b1;
            else                                 latch_cnt <= '0;
            if (load_led) begin
                bit_idx   <= '0;
                shift_reg <= {snap_word[22:0], 1'b0};
            end else if (tx_start) begin
                bit_idx   <= bit_idx + 5'd1;
                shift_reg <= {shift_reg[22:0], 1'b0};
            end else if (state_nx == LATCH) begin
                bit_idx <= '0;
            end
        end
    end

    ws2812_bit_tx #(
        .T_BIT (T_BIT),
        .T1H   (T1H),
        .T0H   (T0H)
    ) u_bit_tx (
        .clk     (clk),
        .reset   (reset),
        .start   (tx_start),
        .bit_val (tx_bit),
        .data    (data),
        .done    (tx_done)
    );

`ifdef WS2812_BUSY_EN
    assign busy = (state == DATA);
`endif

endmodule

// File: tb/tb_ws2812.sv
// Directed testbench for ws2812 (NUM_LEDS=4, 12 MHz timing defaults).
module tb_ws2812;
    import ws2812_pkg::*;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic [23:0] rgb_data = '0;
    logic [7:0]  led_num  = '0;
    logic        write    = 1'b0;
    logic        data;
`ifdef WS2812_BUSY_EN
    logic        busy;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ws2812 #(
        .NUM_LEDS (4),
        .T_BIT    (15),
        .T1H      (9),
        .T0H      (4),
        .T_RESET  (600)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rgb_data (rgb_data),
        .led_num  (led_num),
        .write    (write),
        .data     (data)
`ifdef WS2812_BUSY_EN
        ,
        .busy     (busy)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered at the negedge sampling latch cycle 0; returns at latch cycle 0 of the next frame.
    // exp_bits holds wire-order words {LED0, LED1, LED2, LED3}. Two optional write slots during latch.
    task automatic run_frame(input string tag, input logic [95:0] exp_bits,
                             input logic w0_en, input int w0_at, input logic [7:0] w0_num, input logic [23:0] w0_rgb,
                             input logic w1_en, input int w1_at, input logic [7:0] w1_num, input logic [23:0] w1_rgb);
        int          hi = 0;
        logic [14:0] pat;
        logic        b;
        chk({tag, ":state"}, 32'(dut.state), 32'(LATCH));
        chk({tag, ":led_counter"}, 32'(dut.led_counter), 32'd0);
        for (int i = 0; i < 600; i++) begin
            write = 1'b0;
            if (w0_en && i == w0_at) begin write = 1'b1; led_num = w0_num; rgb_data = w0_rgb; end
            if (w1_en && i == w1_at) begin write = 1'b1; led_num = w1_num; rgb_data = w1_rgb; end
            if (data !== 1'b0) hi++;
            @(negedge clk);
        end
        write = 1'b0;
        chk({tag, ":latch_high"}, 32'(hi), 32'd0);
        for (int led = 0; led < 4; led++) begin
            for (int bt = 0; bt < 24; bt++) begin
                for (int c = 0; c < 15; c++) begin
                    pat[14 - c] = data;
                    @(negedge clk);
                end
                b = exp_bits[95 - (led * 24 + bt)];
                chk($sformatf("%s:L%0d_b%0d", tag, led, bt), 32'(pat),
                    b ? 32'h7FC0 : 32'h7800);
            end
        end
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst:data", 32'(data), 32'd0);
        chk("rst:state", 32'(dut.state), 32'(LATCH));
        chk("rst:led_counter", 32'(dut.led_counter), 32'd0);
        for (int i = 0; i < 4; i++) chk($sformatf("rst:led_reg%0d", i), dut.led_reg[i], 32'd0);

        @(negedge clk);
        reset = 1'b1;

        // All-zero frame
        run_frame("f1", 96'h0, 1'b0, 0, 8'd0, 24'h0, 1'b0, 0, 8'd0, 24'h0);
        // LED0 blue bit 4 -> wire bit 19
        run_frame("f2", {24'h000010, 72'h0}, 1'b1, 0, 8'd0, 24'h000010, 1'b0, 0, 8'd0, 24'h0);
        // LED3 full red -> wire bits 8..15
        run_frame("f3", {72'h0, 24'h00FF00}, 1'b1, 0, 8'd0, 24'h0, 1'b1, 1, 8'd3, 24'hFF0000);
        // Clear LED3, out-of-range index ignored
        run_frame("f4", 96'h0, 1'b1, 0, 8'd3, 24'h0, 1'b1, 1, 8'd7, 24'hFFFFFF);
        for (int i = 0; i < 4; i++) chk($sformatf("oob:led_reg%0d", i), dut.led_reg[i], 32'd0);
        // Write on the LED0 snapshot edge: old value this frame, new value next frame
        run_frame("f5", 96'h0, 1'b1, 599, 8'd0, 24'h123456, 1'b0, 0, 8'd0, 24'h0);
        run_frame("f6", {24'h341256, 72'h0}, 1'b0, 0, 8'd0, 24'h0, 1'b0, 0, 8'd0, 24'h0);

        // Mid-bit reset in LED2 bit 0 (high phase)
        repeat (1322) @(negedge clk);
        chk("abort:pre_data", 32'(data), 32'd1);
        chk("abort:pre_led_counter", 32'(dut.led_counter), 32'd2);
        #2 reset = 1'b0;
        #1;
        chk("abort:data", 32'(data), 32'd0);
        chk("abort:state", 32'(dut.state), 32'(LATCH));
        chk("abort:led_counter", 32'(dut.led_counter), 32'd0);
        chk("abort:led_reg0", dut.led_reg[0], 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_frame("f7", 96'h0, 1'b0, 0, 8'd0, 24'h0, 1'b0, 0, 8'd0, 24'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
